// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty
// thresholds and sticky error flags. Define FIFO_FWFT_EN for first-word fall-through reads.
module fifo_param #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 32,
  parameter int AF_THRESH = DEPTH - 4,
  parameter int AE_THRESH = 4
) (
  input  logic                     CLK,
  input  logic                     RESETH,
  input  logic                     WREN,
  input  logic                     RDEN,
  input  logic [WIDTH-1:0]         DATAIN,
  output logic [WIDTH-1:0]         DATAOUT,
  output logic                     FULL,
  output logic                     EMPTY,
  output logic                     ALMOST_FULL,
  output logic                     ALMOST_EMPTY,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     OVERFLOW,
  output logic                     UNDERFLOW,
  input  logic                     CLR_ERR
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_T    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_T    = CW'(AE_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CW-1:0]    count_nxt;
  logic             pop_ok, push_ok, ovf_set, unf_set;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
  always_comb begin
    pop_ok     = RDEN & ~EMPTY;
    push_ok    = WREN & (~FULL | pop_ok);
    ovf_set    = WREN & FULL & ~pop_ok;
    unf_set    = RDEN & EMPTY;
    rd_ptr_nxt = pop_ok ? rd_ptr + 1'b1 : rd_ptr;
    count_nxt  = COUNT;
    if (push_ok & ~pop_ok)      count_nxt = COUNT + 1'b1;
    else if (pop_ok & ~push_ok) count_nxt = COUNT - 1'b1;
  end

  always_ff @(posedge CLK)
    if (!RESETH && push_ok) mem[wr_ptr] <= DATAIN;

  always_ff @(posedge CLK) begin
    if (RESETH) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      COUNT        <= '0;
      FULL         <= 1'b0;
      EMPTY        <= 1'b1;
      ALMOST_FULL  <= 1'b0;
      ALMOST_EMPTY <= 1'b1;
      OVERFLOW     <= 1'b0;
      UNDERFLOW    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr       <= rd_ptr_nxt;
      COUNT        <= count_nxt;
      FULL         <= (count_nxt == DEPTH_C);
      EMPTY        <= (count_nxt == '0);
      ALMOST_FULL  <= (count_nxt >= AF_T);
      ALMOST_EMPTY <= (count_nxt <= AE_T);
      // A new error event in the same cycle as CLR_ERR keeps the flag set.
      if (ovf_set)      OVERFLOW  <= 1'b1;
      else if (CLR_ERR) OVERFLOW  <= 1'b0;
      if (unf_set)      UNDERFLOW <= 1'b1;
      else if (CLR_ERR) UNDERFLOW <= 1'b0;
    end
  end

`ifdef FIFO_FWFT_EN
  // Register the head the FIFO will have after this edge; bypass DATAIN when
  // the word being written becomes the head (push into an empty/emptying FIFO).
  always_ff @(posedge CLK) begin
    if (RESETH)                              DATAOUT <= '0;
    else if (push_ok && wr_ptr == rd_ptr_nxt) DATAOUT <= DATAIN;
    else                                     DATAOUT <= mem[rd_ptr_nxt];
  end
`else
  always_ff @(posedge CLK) begin
    if (RESETH)      DATAOUT <= '0;
    else if (pop_ok) DATAOUT <= mem[rd_ptr];
  end
`endif
endmodule

// File: tb/tb_fifo_param.sv
// Randomised + directed bench for fifo_param against a queue-based model.
module tb_fifo_param;
  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int AFT   = DEPTH - 4;
  localparam int AET   = 4;

  logic              clk = 1'b0;
  logic              reseth, wren, rden, clr_err;
  logic [WIDTH-1:0]  datain, dataout;
  logic              full, empty, almost_full, almost_empty, overflow, underflow;
  logic [$clog2(DEPTH):0] count;

  fifo_param dut (
    .CLK(clk), .RESETH(reseth), .WREN(wren), .RDEN(rden), .DATAIN(datain),
    .DATAOUT(dataout), .FULL(full), .EMPTY(empty), .ALMOST_FULL(almost_full),
    .ALMOST_EMPTY(almost_empty), .COUNT(count), .OVERFLOW(overflow),
    .UNDERFLOW(underflow), .CLR_ERR(clr_err)
  );

  always #5 clk = ~clk;

  int npass = 0;
  int ntot  = 0;

  // reference model state
  logic [WIDTH-1:0] q[$];
  logic             m_ovf, m_unf;
  logic [WIDTH-1:0] m_dout;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntot++;
    if (obs === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("count", 64'(count), 64'(n));
    chk("full", 64'(full), 64'(n == DEPTH));
    chk("empty", 64'(empty), 64'(n == 0));
    chk("almost_full", 64'(almost_full), 64'(n >= AFT));
    chk("almost_empty", 64'(almost_empty), 64'(n <= AET));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("underflow", 64'(underflow), 64'(m_unf));
`ifdef FIFO_FWFT_EN
    if (n > 0) chk("dataout_fwft", 64'(dataout), 64'(q[0]));
`else
    chk("dataout", 64'(dataout), 64'(m_dout));
`endif
  endtask

  // One clock: drive inputs, advance the model by the spec rules, check after the edge.
  task automatic step(input logic wr, input logic rd, input logic [WIDTH-1:0] din,
                      input logic rst = 1'b0, input logic clr = 1'b0);
    logic pop_ok, push_ok;
    reseth = rst; wren = wr; rden = rd; datain = din; clr_err = clr;
    if (rst) begin
      q.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_dout = '0;
    end else begin
      pop_ok  = rd && q.size() > 0;
      push_ok = wr && (q.size() < DEPTH || pop_ok);
      if (wr && q.size() == DEPTH && !pop_ok) m_ovf = 1'b1;
      else if (clr)                           m_ovf = 1'b0;
      if (rd && q.size() == 0) m_unf = 1'b1;
      else if (clr)            m_unf = 1'b0;
      if (pop_ok)  m_dout = q.pop_front();
      if (push_ok) q.push_back(din);
    end
    @(posedge clk); #1;
    check_all();
  endtask

  initial begin
    reseth = 1'b1; wren = 0; rden = 0; datain = '0; clr_err = 0;
    m_ovf = 0; m_unf = 0; m_dout = '0;
    #1;
    step(0, 0, '0, 1'b1);
    step(0, 0, '0, 1'b1);
    chk("reset_empty", 64'(empty), 64'd1);
    chk("reset_dout", 64'(dataout), 64'd0);

    // fill 1..32
    for (int i = 1; i <= DEPTH; i++) begin
      step(1, 0, WIDTH'(i));
      if (i == 4) chk("ae_still_high_4", 64'(almost_empty), 64'd1);
      if (i == 5) chk("ae_fell_5", 64'(almost_empty), 64'd0);
      if (i == 27) chk("af_low_27", 64'(almost_full), 64'd0);
      if (i == 28) chk("af_rose_28", 64'(almost_full), 64'd1);
    end
    chk("fill_count", 64'(count), 64'd32);
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_no_ovf", 64'(overflow), 64'd0);

    // overflow: 33 dropped
    step(1, 0, 32'd33);
    chk("ovf_set", 64'(overflow), 64'd1);
    chk("ovf_count", 64'(count), 64'd32);

    // drain 1..32, then underflow, then clear
    for (int i = 1; i <= DEPTH; i++) begin
      step(0, 1, '0);
`ifndef FIFO_FWFT_EN
      chk("drain_order", 64'(dataout), 64'(i));
`endif
    end
    chk("drain_empty", 64'(empty), 64'd1);
    step(0, 1, '0);
    chk("unf_set", 64'(underflow), 64'd1);
`ifndef FIFO_FWFT_EN
    chk("unf_dout_hold", 64'(dataout), 64'd32);
`endif
    step(0, 0, '0, 1'b0, 1'b1);
    chk("clr_ovf", 64'(overflow), 64'd0);
    chk("clr_unf", 64'(underflow), 64'd0);

    // COUNT=10, 20 cycles of push+pop
    for (int i = 0; i < 10; i++) step(1, 0, 32'h100 + 32'(i));
    for (int i = 0; i < 20; i++) step(1, 1, 32'h200 + 32'(i));
    chk("simul_count10", 64'(count), 64'd10);

    // full + simultaneous push/pop
    while (q.size() < DEPTH) step(1, 0, $urandom);
    step(1, 1, 32'h5A5A5A5A);
    chk("full_simul_full", 64'(full), 64'd1);
    chk("full_simul_no_ovf", 64'(overflow), 64'd0);

    // empty + simultaneous push/pop
    while (q.size() > 0) step(0, 1, '0);
    step(1, 1, 32'h77);
    chk("empty_simul_count", 64'(count), 64'd1);
    chk("empty_simul_unf", 64'(underflow), 64'd1);
    step(0, 1, '0, 1'b0, 1'b1);

    // three wrap-around passes
    for (int p = 0; p < 3; p++) begin
      for (int n = 0; n < DEPTH; n++) step(1, 0, 32'hA0000000 + 32'(p * DEPTH + n));
      for (int n = 0; n < DEPTH; n++) begin
        step(0, 1, '0);
`ifndef FIFO_FWFT_EN
        chk("wrap_data", 64'(dataout), 64'(32'hA0000000 + 32'(p * DEPTH + n)));
`endif
      end
    end

    // reset mid-stream
    for (int i = 0; i < 7; i++) step(1, 0, $urandom);
    step(0, 0, '0, 1'b1);
    chk("midrst_count", 64'(count), 64'd0);
    chk("midrst_empty", 64'(empty), 64'd1);
    chk("midrst_dout", 64'(dataout), 64'd0);
    step(1, 0, 32'hDEADBEEF);
`ifdef FIFO_FWFT_EN
    chk("fwft_head", 64'(dataout), 64'hDEADBEEF);
`endif
    step(0, 1, '0);
`ifndef FIFO_FWFT_EN
    chk("midrst_pop", 64'(dataout), 64'hDEADBEEF);
`endif

    // random phase: bias alternates between filling and draining
    for (int c = 0; c < 3000; c++) begin
      int wp, rp;
      wp = ((c / 200) % 2 == 0) ? 70 : 30;
      rp = 100 - wp;
      step(($urandom_range(99) < wp), ($urandom_range(99) < rp), $urandom,
           ($urandom_range(299) == 0), ($urandom_range(31) == 0));
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
